tcm_dual_port_mem: RTL and testbench

- 128 KB tightly-coupled memory, single clock, two ports: a 64-bit instruction-fetch port and a 32-bit data load/store port.
- Sits directly beside the dual-issue RISC-V core and is its only memory.
- Base address 0x8000_0000 maps to RAM word 0.
- Supports simulation backdoor byte loading for program images.

---
 rtl/tcm_dual_port_mem_pkg.sv | 15 +
 rtl/tcm_mem_ram.sv | 61 ++++++
 rtl/tcm_dual_port_mem.sv | 135 +++++++++++++
 tb/tb_tcm_dual_port_mem.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tcm_dual_port_mem_pkg.sv
// ---------------------------------------------------------------------------
// tcm_dual_port_mem_pkg
//   Shared constants for the tightly-coupled memory beside the dual-issue
//   RISC-V core:
//     MEM_BASE    physical address of RAM byte 0
//     TCM_ADDR_W  default log2 of the number of 64-bit RAM words (128 KB)
//     TAG_W       width of the data-port request/response tag
// ---------------------------------------------------------------------------
package tcm_dual_port_mem_pkg;

  localparam logic [31:0] MEM_BASE   = 32'h8000_0000;
  localparam int          TCM_ADDR_W = 14;
  localparam int          TAG_W      = 11;

endpackage

// File: rtl/tcm_mem_ram.sv
// ---------------------------------------------------------------------------
// tcm_mem_ram
//   Dual-port 64-bit synchronous RAM, both ports read-first.
//   Ports:
//     clk, rst      clock; synchronous active-high reset of the read registers
//                   only (array contents are never cleared)
//     a_en/a_addr   port A read-only (instruction fetch), a_rdata registered
//     b_en          port B read enable (load), b_rdata registered
//     b_we          port B per-byte write enables (8 lanes)
//     b_addr        port B word index
//     b_wdata       port B write data
//   The simulation-only task write(addr, data) loads one byte of the array
//   at zero time, for program images; it works while reset is held.
// ---------------------------------------------------------------------------
module tcm_mem_ram
  import tcm_dual_port_mem_pkg::*;
#(
  parameter int ADDR_W = TCM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [63:0]       a_rdata,
  input  logic              b_en,
  input  logic [7:0]        b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [63:0]       b_wdata,
  output logic [63:0]       b_rdata
);

  logic [63:0] ram [2**ADDR_W];

  // Byte-lane writes. A plain clocked always is used because the backdoor
  // task below also deposits into the array.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (b_we[i]) ram[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
    end
  end

  // Read registers sample the array with non-blocking semantics, so a read
  // of a word written on the same edge returns the old contents. They hold
  // their value when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) a_rdata <= ram[a_addr];
      if (b_en) b_rdata <= ram[b_addr];
    end
  end

`ifndef SYNTHESIS
  task write(input logic [31:0] addr, input logic [7:0] data);
    ram[addr[ADDR_W+2:3]][{addr[2:0], 3'b000} +: 8] <= data;
  endtask
`endif

endmodule

// File: rtl/tcm_dual_port_mem.sv
// ---------------------------------------------------------------------------
// tcm_dual_port_mem
//   128 KB tightly-coupled memory with a 64-bit fetch port and a 32-bit
//   load/store port, single clock, one-cycle response latency on both.
//   Ports:
//     clk_i, rst_i               clock, synchronous active-high reset
//     mem_i_*                    fetch: rd/pc in, accept/valid/error/inst out
//                                (flush/invalidate accepted, no effect)
//     mem_d_*                    data: addr/data_wr/rd/wr strobes/tag and
//                                maintenance requests in; data_rd/accept/
//                                ack/error/resp_tag out (cacheable ignored)
//   Optional macro TCM_ADDR_CHECK_EN: out-of-window accesses still respond
//   but flag error, and out-of-window stores are dropped. Without it the
//   error outputs are 0 and addresses alias modulo 128 KB.
// ---------------------------------------------------------------------------
module tcm_dual_port_mem
  import tcm_dual_port_mem_pkg::*;
#(
  parameter logic [31:0] BASE   = MEM_BASE,
  parameter int          ADDR_W = TCM_ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_i_rd_i,
  input  logic             mem_i_flush_i,
  input  logic             mem_i_invalidate_i,
  input  logic [31:0]      mem_i_pc_i,
  output logic             mem_i_accept_o,
  output logic             mem_i_valid_o,
  output logic             mem_i_error_o,
  output logic [63:0]      mem_i_inst_o,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic [31:0]      mem_d_data_rd_o,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o
);

  logic        d_req;
  logic        store_ok;
  logic [7:0]  b_we;
  logic [63:0] b_rdata;
  logic        lane_q;
  logic        unused_ok;

  assign mem_i_accept_o = 1'b1;
  assign mem_d_accept_o = 1'b1;

  assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i |
                 mem_d_writeback_i | mem_d_flush_i;

`ifdef TCM_ADDR_CHECK_EN
  localparam logic [31:0] WIN_SIZE = 32'd1 << (ADDR_W + 3);

  logic [31:0] i_off;
  logic [31:0] d_off;
  logic        i_in_range;
  logic        d_in_range;
  logic        i_err_q;
  logic        d_err_q;

  // Offset compare handles the window without a separate upper-bound check;
  // addresses below BASE wrap to a large offset.
  assign i_off      = mem_i_pc_i - BASE;
  assign d_off      = mem_d_addr_i - BASE;
  assign i_in_range = i_off < WIN_SIZE;
  assign d_in_range = d_off < WIN_SIZE;
  assign store_ok   = d_in_range;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      i_err_q <= mem_i_rd_i & ~i_in_range;
      d_err_q <= d_req & ~d_in_range;
    end
  end

  assign mem_i_error_o = i_err_q;
  assign mem_d_error_o = d_err_q;
`else
  assign store_ok      = 1'b1;
  assign mem_i_error_o = 1'b0;
  assign mem_d_error_o = 1'b0;
`endif

  // The 4 store strobes land in the lower or upper half of the 64-bit word.
  assign b_we = !store_ok      ? 8'h00 :
                mem_d_addr_i[2] ? {mem_d_wr_i, 4'h0} : {4'h0, mem_d_wr_i};

  tcm_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk_i),
    .rst     (rst_i),
    .a_en    (mem_i_rd_i),
    .a_addr  (mem_i_pc_i[ADDR_W+2:3]),
    .a_rdata (mem_i_inst_o),
    .b_en    (mem_d_rd_i),
    .b_we    (b_we),
    .b_addr  (mem_d_addr_i[ADDR_W+2:3]),
    .b_wdata ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .b_rdata (b_rdata)
  );

  // Response strobes and tag. Reset wins over a request captured on the
  // same edge, so a request in flight at reset never acks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_i_valid_o    <= 1'b0;
      mem_d_ack_o      <= 1'b0;
      mem_d_resp_tag_o <= '0;
      lane_q           <= 1'b0;
    end else begin
      mem_i_valid_o <= mem_i_rd_i;
      mem_d_ack_o   <= d_req;
      if (d_req)      mem_d_resp_tag_o <= mem_d_req_tag_i;
      if (mem_d_rd_i) lane_q           <= mem_d_addr_i[2];
    end
  end

  assign mem_d_data_rd_o = lane_q ? b_rdata[63:32] : b_rdata[31:0];

  assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                       mem_i_pc_i, mem_d_addr_i};

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// ---------------------------------------------------------------------------
// tb_tcm_dual_port_mem
//   Directed self-checking bench for tcm_dual_port_mem: reset values,
//   fetch, byte-strobed stores, loads, read-first collisions, tag echo,
//   reset dropping a request, and out-of-window behaviour (error with
//   TCM_ADDR_CHECK_EN, aliasing without).
// ---------------------------------------------------------------------------
module tb_tcm_dual_port_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        iRd, iFlush, iInval;
  logic [31:0] iPc;
  logic        iAccept, iValid, iError;
  logic [63:0] iInst;
  logic [31:0] dAddr, dDataWr, dDataRd;
  logic        dRd, dCacheable, dInval, dWriteback, dFlush;
  logic [3:0]  dWr;
  logic [10:0] dReqTag, dRespTag;
  logic        dAccept, dAck, dError;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  tcm_dual_port_mem u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_i_rd_i         (iRd),
    .mem_i_flush_i      (iFlush),
    .mem_i_invalidate_i (iInval),
    .mem_i_pc_i         (iPc),
    .mem_i_accept_o     (iAccept),
    .mem_i_valid_o      (iValid),
    .mem_i_error_o      (iError),
    .mem_i_inst_o       (iInst),
    .mem_d_addr_i       (dAddr),
    .mem_d_data_wr_i    (dDataWr),
    .mem_d_rd_i         (dRd),
    .mem_d_wr_i         (dWr),
    .mem_d_cacheable_i  (dCacheable),
    .mem_d_req_tag_i    (dReqTag),
    .mem_d_invalidate_i (dInval),
    .mem_d_writeback_i  (dWriteback),
    .mem_d_flush_i      (dFlush),
    .mem_d_data_rd_o    (dDataRd),
    .mem_d_accept_o     (dAccept),
    .mem_d_ack_o        (dAck),
    .mem_d_error_o      (dError),
    .mem_d_resp_tag_o   (dRespTag)
  );

  task checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the data port; fetch inputs are set directly.
  task applyStimulus(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [10:0] tag);
    dRd     = rd;
    dWr     = wr;
    dAddr   = addr;
    dDataWr = data;
    dReqTag = tag;
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    iRd = 0; iFlush = 0; iInval = 0; iPc = 32'h8000_0000;
    dCacheable = 0; dInval = 0; dWriteback = 0; dFlush = 0;
    applyStimulus(0, 4'h0, 32'h8000_0000, 32'h0, 11'h0);

    // Program image: bytes 0x00..0x07 at offset 0, loaded during reset.
    for (int i = 0; i < 8; i++) u_dut.u_ram.write(32'h8000_0000 + i, 8'(i));
    tick();
    tick();
    checkOutput("rst_i_valid", iValid, 0);
    checkOutput("rst_d_ack", dAck, 0);
    checkOutput("rst_d_tag", dRespTag, 0);
    checkOutput("rst_d_data", dDataRd, 0);
    checkOutput("rst_i_inst", iInst, 0);
    checkOutput("rst_errors", {iError, dError}, 0);
    checkOutput("accepts", {iAccept, dAccept}, 2'b11);

    @(negedge clk);
    rst = 1'b0;

    // Fetch of the backdoor image.
    iRd = 1; iPc = 32'h8000_0000;
    tick();
    checkOutput("fetch_valid", iValid, 1);
    checkOutput("fetch_inst", iInst, 64'h0706050403020100);
    checkOutput("fetch_err", iError, 0);
    iRd = 0;
    tick();
    checkOutput("fetch_idle_valid", iValid, 0);
    checkOutput("fetch_hold_inst", iInst, 64'h0706050403020100);

    // Full-word store to lower half, then load it back.
    applyStimulus(0, 4'hF, 32'h8000_0000, 32'h0000_00CD, 11'h010);
    tick();
    checkOutput("store_ack", dAck, 1);
    checkOutput("store_tag", dRespTag, 11'h010);
    checkOutput("ram0_lo", u_dut.u_ram.ram[0][31:0], 32'h0000_00CD);
    applyStimulus(1, 4'h0, 32'h8000_0000, 32'h0, 11'h011);
    tick();
    checkOutput("load_ack", dAck, 1);
    checkOutput("load_data", dDataRd, 32'h0000_00CD);
    applyStimulus(0, 4'h0, 32'h8000_0000, 32'h0, 11'h0);
    tick();
    checkOutput("idle_ack", dAck, 0);

    // Upper-half store leaves lower half alone.
    applyStimulus(0, 4'hF, 32'h8000_0004, 32'hFFFF_FFFB, 11'h0);
    tick();
    checkOutput("ram0_hi", u_dut.u_ram.ram[0][63:32], 32'hFFFF_FFFB);
    checkOutput("ram0_lo_kept", u_dut.u_ram.ram[0][31:0], 32'h0000_00CD);
    applyStimulus(1, 4'h0, 32'h8000_0004, 32'h0, 11'h0);
    tick();
    checkOutput("load_hi", dDataRd, 32'hFFFF_FFFB);

    // Partial strobe merges a single byte.
    applyStimulus(0, 4'hF, 32'h8000_0008, 32'h1122_3344, 11'h0);
    tick();
    applyStimulus(0, 4'h2, 32'h8000_0008, 32'h0000_AB00, 11'h0);
    tick();
    applyStimulus(1, 4'h0, 32'h8000_0008, 32'h0, 11'h0);
    tick();
    checkOutput("strobe_merge", dDataRd, 32'h1122_AB44);

    // Word 2 primed, then store+load+fetch to it in one cycle: read-first.
    applyStimulus(0, 4'hF, 32'h8000_0014, 32'h0BAD_F00D, 11'h0);
    tick();
    applyStimulus(0, 4'hF, 32'h8000_0010, 32'hAAAA_5555, 11'h0);
    tick();
    applyStimulus(1, 4'hF, 32'h8000_0010, 32'h1234_5678, 11'h0);
    iRd = 1; iPc = 32'h8000_0010;
    tick();
    checkOutput("collide_fetch_old", iInst, 64'h0BAD_F00D_AAAA_5555);
    checkOutput("collide_load_old", dDataRd, 32'hAAAA_5555);
    applyStimulus(0, 4'h0, 32'h8000_0010, 32'h0, 11'h0);
    tick();
    checkOutput("refetch_new", iInst, 64'h0BAD_F00D_1234_5678);
    iRd = 0;

    // Back-to-back load and flush with tag echo.
    applyStimulus(1, 4'h0, 32'h8000_0000, 32'h0, 11'h5A5);
    tick();
    checkOutput("b2b_ack0", dAck, 1);
    checkOutput("b2b_tag0", dRespTag, 11'h5A5);
    applyStimulus(0, 4'h0, 32'h8000_0000, 32'h0, 11'h001);
    dFlush = 1;
    tick();
    checkOutput("b2b_ack1", dAck, 1);
    checkOutput("b2b_tag1", dRespTag, 11'h001);
    dFlush = 0;
    tick();
    checkOutput("b2b_idle", dAck, 0);

    // Out-of-window load (and a store that aliases to word 0 if unchecked).
    applyStimulus(1, 4'h0, 32'h9000_0000, 32'h0, 11'h00F);
    tick();
    checkOutput("oow_ack", dAck, 1);
`ifdef TCM_ADDR_CHECK_EN
    checkOutput("oow_err", dError, 1);
    applyStimulus(0, 4'hF, 32'h9000_0000, 32'hDEAD_BEEF, 11'h0);
    tick();
    checkOutput("oow_store_err", dError, 1);
    checkOutput("oow_store_dropped", u_dut.u_ram.ram[0], 64'hFFFF_FFFB_0000_00CD);
    iRd = 1; iPc = 32'h7FFF_FFF8;
    tick();
    checkOutput("oow_fetch_err", iError, 1);
    checkOutput("oow_fetch_valid", iValid, 1);
    iRd = 0;
`else
    checkOutput("alias_err", dError, 0);
    checkOutput("alias_load", dDataRd, 32'h0000_00CD);
`endif
    applyStimulus(0, 4'h0, 32'h8000_0000, 32'h0, 11'h0);
    tick();

    // Request captured on a reset edge is dropped.
    applyStimulus(1, 4'h0, 32'h8000_0000, 32'h0, 11'h123);
    rst = 1'b1;
    tick();
    checkOutput("rst_drop_ack", dAck, 0);
    checkOutput("rst_drop_tag", dRespTag, 0);
    checkOutput("rst_keeps_ram", u_dut.u_ram.ram[1], {32'h0, 32'h1122_AB44} | (u_dut.u_ram.ram[1] & 64'hFFFF_FFFF_0000_0000));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
